// File: rtl/itch5_msg_asm_if.sv
// Beat-in / message-out bundle for the ITCH 5.0 message assembler.
// The slave modport is the assembler side; master is the upstream feeder and result consumer.
interface itch5_msg_asm_if #(
  parameter int AXI_DATA_W    = 64,
  parameter int MSG_MAX_BYTES = 50
);
  localparam int AXI_KEEP_W = AXI_DATA_W / 8;
  localparam int MAX_W      = MSG_MAX_BYTES * 8;

  logic                  mold_v_i;
  logic                  mold_start_i;
  logic [AXI_DATA_W-1:0] mold_data_i;
  logic [AXI_KEEP_W-1:0] mold_keep_i;

  logic                  itch_v_o;
  logic [7:0]            itch_type_o;
  logic [5:0]            itch_len_o;
  logic [MAX_W-1:0]      itch_data_o;
  logic [1:0]            itch_err_o;

  modport master (
    output mold_v_i, mold_start_i, mold_data_i, mold_keep_i,
    input  itch_v_o, itch_type_o, itch_len_o, itch_data_o, itch_err_o
  );

  modport slave (
    input  mold_v_i, mold_start_i, mold_data_i, mold_keep_i,
    output itch_v_o, itch_type_o, itch_len_o, itch_data_o, itch_err_o
  );
endinterface

// File: rtl/itch5_msg_asm.sv
// ITCH 5.0 message assembler: gathers keep-qualified beats into a flat message register,
// checks the byte count against the type's length and reports each message as a one-cycle pulse.
module itch5_msg_asm #(
  parameter int AXI_DATA_W    = 64,
  parameter int AXI_KEEP_W    = AXI_DATA_W / 8,
  parameter int MSG_MAX_BYTES = 50,
  parameter int MAX_W         = MSG_MAX_BYTES * 8,
  parameter int BCNT_W        = $clog2(MSG_MAX_BYTES + AXI_KEEP_W + 1)
) (
  input  logic            clk,
  input  logic            nreset,
  itch5_msg_asm_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DROP} state_t;

  function automatic logic [5:0] itch_len_lut(input logic [7:0] t);
    case (t)
      "S", "W":           return 6'd12;
      "R":                return 6'd39;
      "H":                return 6'd25;
      "Y", "N":           return 6'd20;
      "L":                return 6'd26;
      "V", "J", "U":      return 6'd35;
      "K":                return 6'd28;
      "h":                return 6'd21;
      "A", "C":           return 6'd36;
      "F", "Q":           return 6'd40;
      "E":                return 6'd31;
      "X":                return 6'd23;
      "D", "B":           return 6'd19;
      "P":                return 6'd44;
      "I":                return 6'd50;
      default:            return 6'd0;
    endcase
  endfunction

  state_t             state_reg;
  logic [BCNT_W-1:0]  cnt_reg;
  logic [MAX_W-1:0]   msg_reg;
  logic [7:0]         type_reg;
  logic [5:0]         len_reg;

  logic               itch_v_reg;
  logic [7:0]         itch_type_reg;
  logic [5:0]         itch_len_reg;
  logic [MAX_W-1:0]   itch_data_reg;
  logic [1:0]         itch_err_reg;

  logic               hold_v_reg;
  logic [7:0]         hold_type_reg;
  logic [5:0]         hold_len_reg;
  logic [MAX_W-1:0]   hold_data_reg;
  logic [1:0]         hold_err_reg;

  logic               beat_start, beat_cont, abort;
  logic [BCNT_W-1:0]  wr_off, pop, cnt_next;
  logic [MAX_W-1:0]   base_msg, asm_msg;
  logic [7:0]         type_next;
  logic [5:0]         len_next;
  logic               res_v;
  logic [1:0]         res_err;

  assign beat_start = bus.mold_v_i & bus.mold_start_i;
  assign beat_cont  = bus.mold_v_i & ~bus.mold_start_i & (state_reg == ACCUM);
  assign abort      = beat_start & (state_reg == ACCUM);
  assign wr_off     = beat_start ? '0 : cnt_reg;
  assign base_msg   = beat_start ? '0 : msg_reg;
  assign type_next  = beat_start ? bus.mold_data_i[7:0] : type_reg;
  assign len_next   = beat_start ? itch_len_lut(bus.mold_data_i[7:0]) : len_reg;
  assign cnt_next   = wr_off + pop;

  always_comb begin
    pop = '0;
    for (int k = 0; k < AXI_KEEP_W; k++)
      pop = pop + BCNT_W'(bus.mold_keep_i[k]);
  end

  // Each message byte picks whichever kept lane lands on it; bytes past MSG_MAX_BYTES have no slot.
  for (genvar gi = 0; gi < MSG_MAX_BYTES; gi++) begin : g_byte
    logic [7:0] byte_d;
    always_comb begin
      byte_d = base_msg[8*gi +: 8];
      for (int k = 0; k < AXI_KEEP_W; k++)
        if (bus.mold_keep_i[k] && ((wr_off + BCNT_W'(k)) == BCNT_W'(gi)))
          byte_d = bus.mold_data_i[8*k +: 8];
    end
    assign asm_msg[8*gi +: 8] = byte_d;
  end

  always_comb begin
    res_v   = 1'b0;
    res_err = 2'd0;
    if (beat_start && (len_next == 6'd0)) begin
      res_v   = 1'b1;
      res_err = 2'd1;
    end else if ((beat_start || beat_cont) && (cnt_next >= BCNT_W'(len_next))) begin
      res_v   = 1'b1;
      res_err = (cnt_next == BCNT_W'(len_next)) ? 2'd0 : 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      msg_reg       <= '0;
      type_reg      <= '0;
      len_reg       <= '0;
      itch_v_reg    <= 1'b0;
      itch_type_reg <= '0;
      itch_len_reg  <= '0;
      itch_data_reg <= '0;
      itch_err_reg  <= '0;
      hold_v_reg    <= 1'b0;
      hold_type_reg <= '0;
      hold_len_reg  <= '0;
      hold_data_reg <= '0;
      hold_err_reg  <= '0;
    end else begin
      if (beat_start || beat_cont) begin
        msg_reg  <= asm_msg;
        cnt_reg  <= cnt_next;
        type_reg <= type_next;
        len_reg  <= len_next;
        if (res_v)
          state_reg <= (res_err == 2'd1) ? DROP : IDLE;
        else
          state_reg <= ACCUM;
      end

      // At most one result arrives per cycle, so a single holding slot absorbs the abort collision.
      if (abort) begin
        itch_v_reg    <= 1'b1;
        itch_type_reg <= type_reg;
        itch_len_reg  <= len_reg;
        itch_data_reg <= msg_reg;
        itch_err_reg  <= 2'd3;
        hold_v_reg    <= res_v;
        hold_type_reg <= type_next;
        hold_len_reg  <= len_next;
        hold_data_reg <= asm_msg;
        hold_err_reg  <= res_err;
      end else if (hold_v_reg) begin
        itch_v_reg    <= 1'b1;
        itch_type_reg <= hold_type_reg;
        itch_len_reg  <= hold_len_reg;
        itch_data_reg <= hold_data_reg;
        itch_err_reg  <= hold_err_reg;
        hold_v_reg    <= res_v;
        hold_type_reg <= type_next;
        hold_len_reg  <= len_next;
        hold_data_reg <= asm_msg;
        hold_err_reg  <= res_err;
      end else if (res_v) begin
        itch_v_reg    <= 1'b1;
        itch_type_reg <= type_next;
        itch_len_reg  <= len_next;
        itch_data_reg <= asm_msg;
        itch_err_reg  <= res_err;
      end else begin
        itch_v_reg    <= 1'b0;
      end
    end
  end

  assign bus.itch_v_o    = itch_v_reg;
  assign bus.itch_type_o = itch_type_reg;
  assign bus.itch_len_o  = itch_len_reg;
  assign bus.itch_data_o = itch_data_reg;
  assign bus.itch_err_o  = itch_err_reg;
endmodule

// File: doc/itch5_msg_asm.md
# itch5_msg_asm

Parametrised ITCH 5.0 message assembler sitting directly behind the MoldUDP64 receiver. Gathers byte-granular AXI beats of one ITCH message into a flat message register, decodes the expected length from the message-type byte, and emits the complete message as a single-cycle pulse. Flags unknown types, length overruns and truncated messages. Replaces the fixed-width beat accumulator with width-generic, keep-aware assembly and length checking.

## Interface
- AXI_DATA_W, 64, beat data width; multiple of 8, minimum 32
- AXI_KEEP_W, AXI_DATA_W/8, byte lanes per beat
- MSG_MAX_BYTES, 50, longest ITCH 5.0 message ('I')
- MAX_W, MSG_MAX_BYTES*8, width of assembled message
- BCNT_W, $clog2(MSG_MAX_BYTES+AXI_KEEP_W+1), byte counter width
- clk  in  1  clock
- nreset  in  1  reset: synchronous, active-high
- mold_v_i  in  1  beat valid
- mold_start_i  in  1  first beat of a message, qualified by mold_v_i
- mold_data_i  in  AXI_DATA_W  beat data; lane k = byte k of beat
- mold_keep_i  in  AXI_KEEP_W  byte enables; contiguous from lane 0
- itch_v_o  out  1  one-cycle pulse: message complete or aborted
- itch_type_o  out  8  message type byte
- itch_len_o  out  6  expected length in bytes (0 if type unknown)
- itch_data_o  out  MAX_W  message; byte n at bits [8n+7:8n], byte 0 = type
- itch_err_o  out  2  0 ok, 1 unknown type, 2 length overrun, 3 truncated

## Operation
- States: IDLE, ACCUM, DROP.
- Length table (bytes): S 12, R 39, H 25, Y 20, L 26, V 35, W 12, K 28, J 35, h 21, A 36, F 40, E 31, C 36, X 23, D 19, U 35, P 44, Q 40, B 19, I 50, N 20. Other types are unknown.
- Start beat (mold_v_i & mold_start_i), accepted in any state: clear itch_data_o storage to 0, write kept lanes at byte offset 0, byte count = popcount(keep), latch type = lane 0 and expected length.
  - Unknown type: go to DROP, pulse itch_v_o with err 1, len 0.
  - Count == expected: complete, err 0, go to IDLE. Count > expected: complete, err 2, go to IDLE. Otherwise go to ACCUM.
- Continuation beat (mold_v_i & ~mold_start_i) in ACCUM: write kept lanes at offset = count; count += popcount(keep); complete on == (err 0) or > (err 2), as above. Bytes beyond MSG_MAX_BYTES are discarded, never written out of range.
- Continuation beats in IDLE or DROP are discarded silently.
- Start beat while in ACCUM: previous message reported with err 3 (its partial data, type, len), then new message assembly proceeds from the start beat.
- Non-contiguous keep or mold_start_i with keep lane 0 clear: illegal input, behaviour undefined.
- Counter arithmetic: BCNT_W bits, cannot wrap because writes stop at ACCUM exit.

## Timing
- Reset: state IDLE, count 0, itch_v_o 0, itch_err_o 0, itch_type_o 0, itch_len_o 0, itch_data_o 0.
- Latency: itch_v_o asserts the cycle after the completing (or unknown-type start) beat; outputs registered.
- itch_type_o/len/data/err hold their values until the next itch_v_o pulse.
- Truncation: abort pulse (err 3) appears the cycle after the interrupting start beat. If that start beat itself completes (single-beat message at wide AXI_DATA_W) or is unknown-type, the abort pulse is issued first and the new result one cycle later; a one-entry result holding register provides this.
- No backpressure; one beat accepted every cycle mold_v_i is high.
- Reset mid-message discards all state; no pulse emitted.

## Test plan
- 'S' (12 bytes), 64-bit: start beat keep 0xFF, next beat keep 0x0F -> itch_v_o one cycle later, type 0x53, len 12, err 0, bytes 12..49 zero.
- 'I' (50 bytes): 6 full beats + beat keep 0x03 -> single pulse, len 50, err 0, byte 49 matches last lane 1.
- 'D' (19 bytes) sent as 8+8+8 bytes -> err 2, type 0x44, len 19, bytes 16..18 correct, no write past byte 49.
- 'A' start beat, one continuation, then new 'S' start -> pulse err 3 type 0x41, then 'S' completes normally.
- Type 0x5A start beat, two continuations -> one pulse err 1, len 0; continuations produce nothing.
- Reset asserted after second beat of 'P' -> no pulse; all outputs 0 next cycle; following 'S' completes with err 0.
